// File: rtl/cpu8_pkg.sv
// Shared constants and types for the cpu8 core: field widths, opcodes and FSM states.
package cpu8_pkg;

    localparam int DATA_W = 8;
    localparam int REG_W  = 4;
    localparam int ADDR_W = 8;
    localparam int OP_W   = 4;
    localparam int NREGS  = 1 << REG_W;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [OP_W-1:0] OP_LDI  = 4'h0;
    localparam logic [OP_W-1:0] OP_ST   = 4'h1;
    localparam logic [OP_W-1:0] OP_LD   = 4'h2;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h3;
    localparam logic [OP_W-1:0] OP_SUBI = 4'h4;
    localparam logic [OP_W-1:0] OP_ANDI = 4'h5;
    localparam logic [OP_W-1:0] OP_ORI  = 4'h6;
    localparam logic [OP_W-1:0] OP_XORI = 4'h7;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_t;

endpackage

// File: rtl/cpu8_dmem.sv
// 256x8 data memory: synchronous write, combinational read, contents survive reset.
module cpu8_dmem
    import cpu8_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[addr] <= wdata;
        end
    end

    assign rdata = mem_reg[addr];

endmodule

// File: rtl/cpu8.sv
// cpu8 top: two-cycle FETCH/EXECUTE core with 16x8 register file and 256x8 data memory.
// Defining CPU8_ALU_EXT_EN adds SUBI/ANDI/ORI/XORI (opcodes 0x4-0x7); otherwise they are NOPs.
module cpu8
    import cpu8_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] result
);

    state_t            state_reg;
    logic [15:0]       ir_reg;
    logic [DATA_W-1:0] regs_reg [NREGS];
    logic [DATA_W-1:0] result_reg;

    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  rd;
    logic [ADDR_W-1:0] imm;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] wr_val_next;
    logic              reg_we_next;
    logic              mem_op;
    logic              exec;

    assign op     = ir_reg[15:12];
    assign rd     = ir_reg[11:8];
    assign imm    = ir_reg[7:0];
    assign rd_val = regs_reg[rd];
    assign exec   = (state_reg == S_EXEC);

    always_comb begin
        reg_we_next = 1'b0;
        wr_val_next = '0;
        mem_op      = 1'b0;
        case (op)
            OP_LDI:  begin reg_we_next = 1'b1; wr_val_next = imm;          end
            OP_ST:   begin mem_op = 1'b1;                                  end
            OP_LD:   begin reg_we_next = 1'b1; wr_val_next = mem_rdata;    end
            OP_ADDI: begin reg_we_next = 1'b1; wr_val_next = rd_val + imm; end
`ifdef CPU8_ALU_EXT_EN
            OP_SUBI: begin reg_we_next = 1'b1; wr_val_next = rd_val - imm; end
            OP_ANDI: begin reg_we_next = 1'b1; wr_val_next = rd_val & imm; end
            OP_ORI:  begin reg_we_next = 1'b1; wr_val_next = rd_val | imm; end
            OP_XORI: begin reg_we_next = 1'b1; wr_val_next = rd_val ^ imm; end
`endif
            default: ;
        endcase
    end

    // Reset on the EXECUTE edge must suppress the store as well as the register write.
    cpu8_dmem u_dmem (
        .clk   (clk),
        .we    (exec && mem_op && !reset),
        .addr  (imm),
        .wdata (rd_val),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_FETCH;
            ir_reg     <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    ir_reg    <= instr;
                    state_reg <= S_EXEC;
                end
                S_EXEC: begin
                    state_reg <= S_FETCH;
                    if (reg_we_next) begin
                        result_reg <= wr_val_next;
                    end else if (mem_op) begin
                        result_reg <= rd_val;
                    end
                end
                default: state_reg <= S_FETCH;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
            always_ff @(posedge clk) begin
                if (reset) begin
                    regs_reg[gi] <= '0;
                end else if (exec && reg_we_next && rd == REG_W'(gi)) begin
                    regs_reg[gi] <= wr_val_next;
                end
            end
        end
    endgenerate

    assign result = result_reg;

endmodule

// File: tb/tb_cpu8.sv
// Self-checking bench for cpu8: architectural model of registers/memory plus per-cycle result check.
module tb_cpu8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr = 16'h0000;
    logic [7:0]  result;

    cpu8 dut (
        .clk    (clk),
        .reset  (reset),
        .instr  (instr),
        .result (result)
    );

    always #5 clk = ~clk;

    // Architectural model
    logic [7:0] m_regs [16];
    logic [7:0] m_mem  [256];
    logic [7:0] m_result;

    // Compare-process state
    int         n_vec = 0;
    int         n_err = 0;
    bit         chk_on = 1'b0;
    bit         lit_pending = 1'b0;
    logic [7:0] lit_exp;
    string      lit_name;

    always @(negedge clk) begin
        if (chk_on) begin
            n_vec++;
            if (result !== m_result) begin
                n_err++;
                $display("FAIL cycle_result: got %02h, want %02h (t=%0t)", result, m_result, $time);
            end
        end
        if (lit_pending) begin
            n_vec++;
            if (result !== lit_exp) begin
                n_err++;
                $display("FAIL %s: got %02h, want %02h", lit_name, result, lit_exp);
            end
            lit_pending = 1'b0;
        end
    end

    task automatic model_exec(input logic [15:0] w);
        logic [3:0] op;
        logic [3:0] rd;
        logic [7:0] imm;
        int         v;
        op  = w[15:12];
        rd  = w[11:8];
        imm = w[7:0];
        v   = -1;
        case (op)
            4'h0: v = imm;
            4'h1: begin m_mem[imm] = m_regs[rd]; m_result = m_regs[rd]; end
            4'h2: v = m_mem[imm];
            4'h3: v = (m_regs[rd] + imm) % 256;
`ifdef CPU8_ALU_EXT_EN
            4'h4: v = (m_regs[rd] + 256 - imm) % 256;
            4'h5: v = m_regs[rd] & imm;
            4'h6: v = m_regs[rd] | imm;
            4'h7: v = m_regs[rd] ^ imm;
`endif
            default: ;
        endcase
        if (v >= 0) begin
            m_regs[rd] = 8'(v);
            m_result   = 8'(v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_result = 8'h00;
    endtask

    // Apply one instruction at a FETCH edge; scramble instr afterwards to prove IR latching.
    // exp < 0 means no hand-computed literal for this instruction.
    task automatic issue(input logic [15:0] w, input int exp, input string name);
        instr = w;
        @(posedge clk);
        #1 instr = ~w;
        @(posedge clk);
        #1;
        model_exec(w);
        if (exp >= 0) begin
            lit_exp     = 8'(exp);
            lit_name    = name;
            lit_pending = 1'b1;
        end
        $display("instr %04h -> model result %02h", w, m_result);
    endtask

    task automatic read_reg(input int r, input int exp, input string name);
        logic [3:0] r4;
        r4 = 4'(r);
        issue({4'h3, r4, 8'h00}, exp, name);
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_on = 1'b1;

        lit_exp = 8'h00; lit_name = "reset_result"; lit_pending = 1'b1;
        for (int r = 0; r < 16; r++) read_reg(r, 0, "reset_reg");

        issue(16'h0004, 8'h04, "ldi_r0");
        issue(16'h1002, 8'h04, "st_m2");
        issue(16'h2102, 8'h04, "ld_r1");
        issue(16'h3107, 8'h0B, "addi_r1");
        issue(16'hF123, 8'h0B, "illegal_hold");
        read_reg(1, 8'h0B, "r1_after_nop");
        read_reg(0, 8'h04, "r0_after_nop");

        issue(16'h02FF, 8'hFF, "ldi_r2_ff");
        issue(16'h3202, 8'h01, "addi_wrap");
        issue(16'h1280, 8'h01, "st_m80");
        issue(16'h2580, 8'h01, "ld_r5");
        issue(16'h0AAA, 8'hAA, "ldi_ra");
        issue(16'h3A56, 8'h00, "addi_wrap_zero");

        issue(16'h030F, 8'h0F, "ldi_r3");
`ifdef CPU8_ALU_EXT_EN
        issue(16'h4310, 8'hFF, "subi_r3");
        issue(16'h53F0, 8'hF0, "andi_r3");
        issue(16'h6305, 8'hF5, "ori_r3");
        issue(16'h73FF, 8'h0A, "xori_r3");
`else
        issue(16'h4310, 8'h0F, "subi_nop");
        read_reg(3, 8'h0F, "r3_unchanged");
`endif

        // Reset on the EXECUTE edge of an ADDI: instruction aborted, registers cleared.
        issue(16'h0422, 8'h22, "ldi_r4");
        instr = 16'h3401;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        lit_exp = 8'h00; lit_name = "reset_mid_result"; lit_pending = 1'b1;
        $display("reset during ADDI 3401 -> model result %02h", m_result);
        read_reg(4, 8'h00, "r4_after_reset");
        issue(16'h2602, 8'h04, "mem_survives_reset");

        chk_on = 1'b0;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1);
    end

endmodule
